load_store_unit: RTL and testbench

- Sub-word load/store sequencer placed directly upstream of the word-wide data memory in the multi-cycle RISC-V datapath.
- Accepts one load/store command from the controller per handshake (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives the memory's word-aligned address, write data and write enable. Stores of bytes/halfwords use a read-modify-write sequence.
- Returns sign- or zero-extended load data with a one-cycle done pulse.

---
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer in front of a word-wide data memory (byte/half via read-modify-write).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W commands complete at once with err instead of truncating.
module load_store_unit #(
   parameter int unsigned N     = 32,
   parameter int unsigned ADR_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmdValid,
   input  logic             cmdStore,
   input  logic [2:0]       cmdFunct3,
   input  logic [ADR_W-1:0] cmdAdr,
   input  logic [N-1:0]     cmdWData,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [N-1:0]     loadData,
   output logic [ADR_W-1:0] memAdr,
   output logic [N-1:0]     memWData,
   output logic             memWrite,
   input  logic [N-1:0]     memRData
);
   localparam logic [1:0]  SZ_B = 2'b00;
   localparam logic [1:0]  SZ_H = 2'b01;
   localparam int unsigned SH_W = 5;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t state, stateNext;

   logic             isStore;
   logic [2:0]       funct3;
   logic [1:0]       offset;
   logic [N-1:0]     wData;
   logic             accept, cmdMisalign;
   logic             busyNext, doneNext, errNext, memWriteNext;
   logic [ADR_W-1:0] memAdrNext;
   logic [N-1:0]     memWDataNext, loadDataNext;
   logic [SH_W-1:0]  laneShift;
   logic [N-1:0]     laneMask, rShifted, merged, extended;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      cmdMisalign = 1'b0;
      if (cmdFunct3[1:0] == SZ_H)
         cmdMisalign = cmdAdr[0];
      else if (cmdFunct3[1:0] != SZ_B)
         cmdMisalign = |cmdAdr[1:0];
   end
`else
   assign cmdMisalign = 1'b0;
`endif

   // Lane select/merge/extend from the latched command; halves use offset[1] only.
   always_comb begin
      if (funct3[1:0] == SZ_B) begin
         laneShift = {offset, 3'b000};
         laneMask  = N'(8'hFF) << laneShift;
      end else begin
         laneShift = {offset[1], 4'b0000};
         laneMask  = N'(16'hFFFF) << laneShift;
      end
      rShifted = memRData >> laneShift;
      merged   = (memRData & ~laneMask) | ((wData << laneShift) & laneMask);
      case (funct3[1:0])
         SZ_B:    extended = funct3[2] ? N'(rShifted[7:0])
                                       : {{(N-8){rShifted[7]}}, rShifted[7:0]};
         SZ_H:    extended = funct3[2] ? N'(rShifted[15:0])
                                       : {{(N-16){rShifted[15]}}, rShifted[15:0]};
         default: extended = memRData;
      endcase
   end

   always_comb begin
      stateNext    = state;
      accept       = 1'b0;
      errNext      = 1'b0;
      memAdrNext   = memAdr;
      memWDataNext = memWData;
      loadDataNext = loadData;
      case (state)
         IDLE: begin
            if (cmdValid) begin
               accept = 1'b1;
               if (cmdMisalign) begin
                  stateNext = DONE;
                  errNext   = 1'b1;
               end else begin
                  memAdrNext = {cmdAdr[ADR_W-1:2], 2'b00};
                  if (cmdStore && cmdFunct3[1:0] != SZ_B && cmdFunct3[1:0] != SZ_H) begin
                     stateNext    = WRITE;
                     memWDataNext = cmdWData;
                  end else begin
                     stateNext = READ;
                  end
               end
            end
         end
         READ: begin
            if (isStore) begin
               stateNext    = WRITE;
               memWDataNext = merged;
            end else begin
               stateNext    = DONE;
               loadDataNext = extended;
            end
         end
         WRITE:   stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      busyNext     = (stateNext != IDLE);
      doneNext     = (stateNext == DONE);
      memWriteNext = (stateNext == WRITE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         memWrite <= 1'b0;
         loadData <= '0;
         memAdr   <= '0;
         memWData <= '0;
         isStore  <= 1'b0;
         funct3   <= '0;
         offset   <= '0;
         wData    <= '0;
      end else begin
         state    <= stateNext;
         busy     <= busyNext;
         done     <= doneNext;
         err      <= errNext;
         memWrite <= memWriteNext;
         loadData <= loadDataNext;
         memAdr   <= memAdrNext;
         memWData <= memWDataNext;
         if (accept) begin
            isStore <= cmdStore;
            funct3  <= cmdFunct3;
            offset  <= cmdAdr[1:0];
            wData   <= cmdWData;
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory driven by the DUT, checked against a byte-array reference model.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmdValid, cmdStore;
   logic [2:0]  cmdFunct3;
   logic [31:0] cmdAdr, cmdWData;
   logic        busy, done, err, memWrite;
   logic [31:0] loadData, memAdr, memWData, memRData;

   logic [31:0] mem    [0:255];
   logic [7:0]  refMem [0:1023];
   logic [31:0] refLoad;
   int          checks, failures;

   load_store_unit #(.N(32), .ADR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmdStore(cmdStore),
      .cmdFunct3(cmdFunct3), .cmdAdr(cmdAdr), .cmdWData(cmdWData),
      .busy(busy), .done(done), .err(err), .loadData(loadData),
      .memAdr(memAdr), .memWData(memWData), .memWrite(memWrite), .memRData(memRData)
   );

   always #5 clk = ~clk;
   assign memRData = mem[memAdr[9:2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int sizeOf(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit misaligned(input logic [2:0] f3, input int a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (a % sizeOf(f3)) != 0;
`else
      return (a < 0) && (f3 == 3'b111);
`endif
   endfunction

   function automatic logic [31:0] refWord(input int a);
      int b = a - (a % 4);
      return {refMem[b+3], refMem[b+2], refMem[b+1], refMem[b]};
   endfunction

   function automatic logic [31:0] refLoadFn(input logic [2:0] f3, input int a);
      int sz = sizeOf(f3);
      int b = a - (a % sz);
      logic [31:0] v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = refMem[b+i];
      if (sz < 4 && !f3[2] && v[8*sz-1])
         for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic setWord(input int wa, input logic [31:0] v);
      mem[wa/4] = v;
      for (int i = 0; i < 4; i++) refMem[wa+i] = v[8*i +: 8];
   endtask

   // Issues one command, plays memory, and checks latency, err, writes and load result.
   task automatic runCmd(input logic st, input logic [2:0] f3, input int a,
                         input logic [31:0] wd, input bit hold);
      int sz, b, lat, nWr, expLat;
      logic [31:0] wAdr;
      bit bad;
      string nm;
      sz     = sizeOf(f3);
      b      = a - (a % sz);
      bad    = misaligned(f3, a);
      expLat = bad ? 1 : (!st ? 2 : (sz == 4 ? 2 : 3));
      nm     = $sformatf("%s f3=%0d a=%03h", st ? "ST" : "LD", f3, a);
      cmdValid = 1'b1; cmdStore = st; cmdFunct3 = f3; cmdAdr = 32'(a); cmdWData = wd;
      @(posedge clk); #1;
      cmdValid  = hold;
      cmdStore  = 1'($urandom);
      cmdFunct3 = 3'($urandom);
      cmdAdr    = $urandom;
      cmdWData  = $urandom;
      lat = 0; nWr = 0; wAdr = '0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         if (memWrite) begin
            nWr++;
            wAdr = memAdr;
            mem[memAdr[9:2]] = memWData;
         end
         if (done) begin
            lat = c;
            cmdValid = 1'b0;
         end else begin
            check({nm, " busy"}, 32'(busy), 32'd1);
            @(posedge clk); #1;
         end
      end
      cmdValid = 1'b0;
      check({nm, " latency"}, 32'(lat), 32'(expLat));
      check({nm, " err"}, 32'(err), 32'(bad));
      if (st && !bad)
         for (int i = 0; i < sz; i++) refMem[b+i] = wd[8*i +: 8];
      if (!st && !bad)
         refLoad = refLoadFn(f3, a);
      check({nm, " loadData"}, loadData, refLoad);
      check({nm, " writes"}, 32'(nWr), (st && !bad) ? 32'd1 : 32'd0);
      if (st && !bad)
         check({nm, " wAdr"}, wAdr, 32'(b - (b % 4)));
      check({nm, " memWord"}, mem[b/4], refWord(b));
      @(posedge clk); #1;
      check({nm, " doneLow"}, 32'(done), 32'd0);
      check({nm, " idle"}, 32'(busy), 32'd0);
      check({nm, " wrLow"}, 32'(memWrite), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] f3Pool [8];
      f3Pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      checks = 0; failures = 0;
      rst_n = 1'b0; cmdValid = 1'b0; cmdStore = 1'b0; cmdFunct3 = '0;
      cmdAdr = '0; cmdWData = '0; refLoad = '0;
      for (int w = 0; w < 1024; w += 4) setWord(w, $urandom);
      setWord(32'h100, 32'h8899AABB);
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst err", 32'(err), 32'd0);
      check("rst memWrite", 32'(memWrite), 32'd0);
      check("rst loadData", loadData, 32'd0);
      check("rst memAdr", memAdr, 32'd0);
      check("rst memWData", memWData, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      runCmd(1'b0, 3'b000, 32'h101, 32'h0, 1'b0);
      check("LB 0x101 const", loadData, 32'hFFFFFFAA);
      runCmd(1'b0, 3'b100, 32'h103, 32'h0, 1'b0);
      check("LBU 0x103 const", loadData, 32'h00000088);
      runCmd(1'b0, 3'b001, 32'h102, 32'h0, 1'b0);
      check("LH 0x102 const", loadData, 32'hFFFF8899);
      runCmd(1'b0, 3'b101, 32'h100, 32'h0, 1'b0);
      check("LHU 0x100 const", loadData, 32'h0000AABB);
      runCmd(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
      check("LW 0x100 const", loadData, 32'h8899AABB);
      runCmd(1'b1, 3'b000, 32'h102, 32'h123456CC, 1'b0);
      check("SB 0x102 word", mem[32'h100/4], 32'h88CCAABB);
      runCmd(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 1'b1);
      check("SW 0x200 word", mem[32'h200/4], 32'hDEADBEEF);
      runCmd(1'b0, 3'b010, 32'h102, 32'h0, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
      check("LW 0x102 trunc", loadData, 32'h88CCAABB);
`endif
      runCmd(1'b0, 3'b011, 32'h104, 32'h0, 1'b0);
      runCmd(1'b1, 3'b110, 32'h108, 32'hCAFEF00D, 1'b0);
      runCmd(1'b1, 3'b001, 32'h10E, 32'h00005A5A, 1'b0);

      // Reset during the READ of an SH must abort without any write.
      cmdValid = 1'b1; cmdStore = 1'b1; cmdFunct3 = 3'b001; cmdAdr = 32'h102; cmdWData = 32'h0000BEEF;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort memWrite", 32'(memWrite), 32'd0);
      check("abort memAdr", memAdr, 32'd0);
      check("abort memWData", memWData, 32'd0);
      check("abort loadData", loadData, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check("abort noWrite", 32'(memWrite), 32'd0);
         check("abort noDone", 32'(done), 32'd0);
      end
      refLoad = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort word kept", mem[32'h100/4], 32'h88CCAABB);
      runCmd(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
      check("LW after reset", loadData, 32'h88CCAABB);

      for (int n = 0; n < 80; n++) begin
         runCmd(1'($urandom_range(0, 1)), f3Pool[$urandom_range(0, 7)],
                int'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
